// File: rtl/spi_lcd_responder.sv
// -----------------------------------------------------------------------------
// spi_lcd_responder
//   PCD8544-compatible SPI responder (84x48 mono, 6 banks of 84 columns).
//   Synchronises the serial link from spi_master, deserialises bytes MSB
//   first, decodes commands into the controller register set and writes data
//   bytes into a 504-byte display RAM with auto-increment addressing.
//   A separate read port lets a test environment mirror the display.
//
// Ports
//   clock        system clock, at least 4x the sclk frequency
//   Reset        synchronous, active-low reset
//   sclk/mosi    serial clock / data (MSB first, sampled on sclk rise)
//   sce          chip enable, active-low
//   dc           0 = command, 1 = data (taken with the 8th bit)
//   lcd_rst_n    LCD reset from the link, active-low (RAM is kept)
//   rd_addr      display RAM read address (y*COLS+x), rd_data one cycle later
//   byte_valid   one-cycle pulse per received byte; byte_data/byte_dc hold it
//   x_addr/y_addr         write pointer
//   h_ext/v_mode/power_down/disp_mode/vop/bias/tc   controller registers
//   cmd_err      pulse: out-of-range X/Y or undefined opcode
//   frame_err    pulse: sce released with a partial byte pending
// -----------------------------------------------------------------------------
module spi_lcd_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 84,
  parameter int BANKS       = 6
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       sce,
  input  logic       dc,
  input  logic       lcd_rst_n,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic [6:0] x_addr,
  output logic [2:0] y_addr,
  output logic       h_ext,
  output logic       v_mode,
  output logic       power_down,
  output logic [1:0] disp_mode,
  output logic [6:0] vop,
  output logic [2:0] bias,
  output logic [1:0] tc,
  output logic       cmd_err,
  output logic       frame_err
);

  localparam int         DEPTH = COLS * BANKS;
  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [2:0] Y_MAX = 3'(BANKS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DECODE} rx_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. sce and lcd_rst_n settle to their inactive level.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, sce_sr, dc_sr, rst_sr;
  logic                   sclk_prev;
  logic                   sclk_s, mosi_s, sce_s, dc_s, rst_s, soft_rst, sclk_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware chain.
  always_ff @(posedge clock) begin
    if (!Reset) begin
      sclk_sr   <= '0;
      mosi_sr   <= '0;
      sce_sr    <= '1;
      dc_sr     <= '0;
      rst_sr    <= '1;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sce_sr    <= {sce_sr[SYNC_STAGES-2:0], sce};
      dc_sr     <= {dc_sr[SYNC_STAGES-2:0], dc};
      rst_sr    <= {rst_sr[SYNC_STAGES-2:0], lcd_rst_n};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign sce_s     = sce_sr[SYNC_STAGES-1];
  assign dc_s      = dc_sr[SYNC_STAGES-1];
  assign rst_s     = rst_sr[SYNC_STAGES-1];
  assign soft_rst  = ~rst_s;
  assign sclk_rise = sclk_s & ~sclk_prev;

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  rx_state_t  state_q, state_next;
  logic [2:0] bit_cnt;
  logic [6:0] shift_q;
  logic       shift_en, byte_done, frame_abort;

  always_ff @(posedge clock) begin
    if (!Reset || soft_rst) state_q <= ST_IDLE;
    else                    state_q <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_next  = state_q;
    shift_en    = 1'b0;
    byte_done   = 1'b0;
    frame_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The first sclk rise may coincide with sce being seen low.
        if (!sce_s) begin
          state_next = ST_SHIFT;
          shift_en   = sclk_rise;
        end
      end
      ST_SHIFT: begin
        if (sce_s) begin
          state_next  = ST_IDLE;
          frame_abort = (bit_cnt != 3'd0);
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            byte_done  = 1'b1;
            state_next = ST_DECODE;
          end
        end
      end
      ST_DECODE: state_next = sce_s ? ST_IDLE : ST_SHIFT;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign byte_valid = (state_q == ST_DECODE);

  // ---------------------------------------------------------------------------
  // Deserialiser, command decode and pointer update. A decoded byte sits in
  // byte_data/byte_dc for the whole DECODE cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!Reset || soft_rst) begin
      bit_cnt    <= '0;
      shift_q    <= '0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
      x_addr     <= '0;
      y_addr     <= '0;
      h_ext      <= 1'b0;
      v_mode     <= 1'b0;
      power_down <= 1'b1;
      disp_mode  <= '0;
      vop        <= '0;
      bias       <= '0;
      tc         <= '0;
      cmd_err    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_err   <= 1'b0;
      frame_err <= frame_abort;
      if (frame_abort) bit_cnt <= '0;

      if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;  // wraps 7 -> 0 on the last bit
        shift_q <= {shift_q[5:0], mosi_s};
        if (byte_done) begin
          byte_data <= {shift_q, mosi_s};
          byte_dc   <= dc_s;
        end
      end

      if (state_q == ST_DECODE) begin
        if (byte_dc) begin
          if (!v_mode) begin
            if (x_addr == X_MAX) begin
              x_addr <= '0;
              y_addr <= (y_addr == Y_MAX) ? 3'd0 : y_addr + 3'd1;
            end else begin
              x_addr <= x_addr + 7'd1;
            end
          end else begin
            if (y_addr == Y_MAX) begin
              y_addr <= '0;
              x_addr <= (x_addr == X_MAX) ? 7'd0 : x_addr + 7'd1;
            end else begin
              y_addr <= y_addr + 3'd1;
            end
          end
        end else if (byte_data == 8'h00) begin
          // NOP
        end else if (byte_data[7:3] == 5'b00100) begin
          power_down <= byte_data[2];
          v_mode     <= byte_data[1];
          h_ext      <= byte_data[0];
        end else if (!h_ext) begin
          if (byte_data[7]) begin
            if (byte_data[6:0] <= X_MAX) x_addr  <= byte_data[6:0];
            else                         cmd_err <= 1'b1;
          end else if (byte_data[7:3] == 5'b01000) begin
            if (byte_data[2:0] <= Y_MAX) y_addr  <= byte_data[2:0];
            else                         cmd_err <= 1'b1;
          end else if (byte_data[7:3] == 5'b00001 && !byte_data[1]) begin
            disp_mode <= {byte_data[2], byte_data[0]};
          end else begin
            cmd_err <= 1'b1;
          end
        end else begin
          if (byte_data[7])                    vop  <= byte_data[6:0];
          else if (byte_data[7:3] == 5'b00010) bias <= byte_data[2:0];
          else if (byte_data[7:2] == 6'b000001) tc  <= byte_data[1:0];
          else                                 cmd_err <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display RAM: one write port fed by the decoder, one independent read port.
  // ---------------------------------------------------------------------------
  logic [7:0] mem [DEPTH];
  logic [8:0] wr_addr;
  logic       mem_we;

  assign wr_addr = 9'(y_addr) * 9'(COLS) + 9'(x_addr);
  assign mem_we  = Reset && rst_s && (state_q == ST_DECODE) && byte_dc;

  // NOTE: the RAM array has no reset so it maps onto block memory; the display
  // image survives both Reset and lcd_rst_n.
  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_addr] <= byte_data;
  end

  // A read of the address being written returns the old byte.
  always_ff @(posedge clock) begin
    if (!Reset)                    rd_data <= '0;
    else if (rd_addr < 9'(DEPTH)) rd_data <= mem[rd_addr];
    else                           rd_data <= '0;
  end

endmodule

// File: tb/tb_spi_lcd_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_lcd_responder
//   Directed self-checking bench for spi_lcd_responder. Bytes are bit-banged
//   at sclk = clock/8; pulse outputs are counted by a monitor sampling on the
//   falling clock edge and each test checks deltas and register values.
// -----------------------------------------------------------------------------
module tb_spi_lcd_responder;

  localparam int SYNC_STAGES = 2;

  logic       clock = 1'b0;
  logic       Reset;
  logic       sclk, mosi, sce, dc, lcd_rst_n;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic [6:0] x_addr;
  logic [2:0] y_addr;
  logic       h_ext, v_mode, power_down;
  logic [1:0] disp_mode;
  logic [6:0] vop;
  logic [2:0] bias;
  logic [1:0] tc;
  logic       cmd_err, frame_err;

  int checks   = 0;
  int failures = 0;
  int bv_cnt   = 0;
  int ce_cnt   = 0;
  int fe_cnt   = 0;
  int max_lat  = 0;
  time last_rise = 0;

  spi_lcd_responder #(.SYNC_STAGES(SYNC_STAGES), .COLS(84), .BANKS(6)) dut (
    .clock(clock), .Reset(Reset), .sclk(sclk), .mosi(mosi), .sce(sce), .dc(dc),
    .lcd_rst_n(lcd_rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .x_addr(x_addr), .y_addr(y_addr), .h_ext(h_ext), .v_mode(v_mode),
    .power_down(power_down), .disp_mode(disp_mode), .vop(vop), .bias(bias),
    .tc(tc), .cmd_err(cmd_err), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  always @(posedge sclk) last_rise = $time;

  always @(negedge clock) begin
    if (byte_valid) begin
      bv_cnt++;
      if (int'(($time - last_rise) / 10) > max_lat) max_lat = int'(($time - last_rise) / 10);
    end
    if (cmd_err)   ce_cnt++;
    if (frame_err) fe_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic spi_send(input logic [7:0] b, input logic d, input int nbits,
                          input bit end_frame);
    sce = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      dc   = d;
      repeat (4) @(negedge clock);
      sclk = 1'b1;
      repeat (4) @(negedge clock);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clock);
    if (end_frame) begin
      sce = 1'b1;
      repeat (6) @(negedge clock);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    spi_send(b, 1'b0, 8, 1'b1);
  endtask

  task automatic send_data(input logic [7:0] b);
    spi_send(b, 1'b1, 8, 1'b1);
  endtask

  task automatic read_ram(input logic [8:0] a, output logic [7:0] d);
    @(negedge clock);
    rd_addr = a;
    @(negedge clock);
    d = rd_data;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    Reset = 1'b0; sclk = 1'b0; mosi = 1'b0; sce = 1'b1; dc = 1'b0;
    lcd_rst_n = 1'b1; rd_addr = '0;
    repeat (5) @(negedge clock);
    checks++;
    if ({x_addr, y_addr} !== 10'd0) begin
      failures++; $display("FAIL reset_xy: got x=%0d y=%0d, want 0 0", x_addr, y_addr);
    end
    checks++;
    if ({h_ext, v_mode, power_down, disp_mode} !== 5'b00100) begin
      failures++; $display("FAIL reset_flags: got H=%b V=%b PD=%b D=%b, want 0 0 1 00",
                           h_ext, v_mode, power_down, disp_mode);
    end
    checks++;
    if ({vop, bias, tc} !== 12'd0) begin
      failures++; $display("FAIL reset_vop_bias_tc: got %h %h %h, want 0", vop, bias, tc);
    end
    checks++;
    if ({byte_valid, cmd_err, frame_err, byte_dc, byte_data, rd_data} !== 20'd0) begin
      failures++; $display("FAIL reset_outputs: bv=%b ce=%b fe=%b dc=%b bd=%h rd=%h, want 0",
                           byte_valid, cmd_err, frame_err, byte_dc, byte_data, rd_data);
    end
    Reset = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_init;
    int bv0, ce0;
    bv0 = bv_cnt; ce0 = ce_cnt;
    send_cmd(8'h21);
    checks++;
    if ({h_ext, power_down} !== 2'b10) begin
      failures++; $display("FAIL init_funcset: got H=%b PD=%b, want 1 0", h_ext, power_down);
    end
    send_cmd(8'h90);
    send_cmd(8'h14);
    send_cmd(8'h06);
    send_cmd(8'h20);
    send_cmd(8'h0C);
    checks++;
    if (vop !== 7'h10) begin
      failures++; $display("FAIL init_vop: got %h, want 10", vop);
    end
    checks++;
    if ({bias, tc} !== {3'd4, 2'd2}) begin
      failures++; $display("FAIL init_bias_tc: got bias=%0d tc=%0d, want 4 2", bias, tc);
    end
    checks++;
    if ({h_ext, power_down, v_mode, disp_mode} !== 5'b00010) begin
      failures++; $display("FAIL init_mode: got H=%b PD=%b V=%b D=%b, want 0 0 0 10",
                           h_ext, power_down, v_mode, disp_mode);
    end
    checks++;
    if (ce_cnt - ce0 != 0 || bv_cnt - bv0 != 6) begin
      failures++; $display("FAIL init_pulses: got cmd_err=%0d byte_valid=%0d, want 0 6",
                           ce_cnt - ce0, bv_cnt - bv0);
    end
    checks++;
    if (max_lat < 1 || max_lat > SYNC_STAGES + 2) begin
      failures++; $display("FAIL byte_latency: got %0d clocks, want 1..%0d", max_lat, SYNC_STAGES + 2);
    end
  endtask

  task automatic test_data;
    logic [7:0] d;
    send_cmd(8'hA1);
    send_cmd(8'h42);
    checks++;
    if (x_addr !== 7'd33 || y_addr !== 3'd2) begin
      failures++; $display("FAIL data_setxy: got x=%0d y=%0d, want 33 2", x_addr, y_addr);
    end
    send_data(8'hFE);
    send_data(8'h81);
    checks++;
    if (x_addr !== 7'd35 || y_addr !== 3'd2) begin
      failures++; $display("FAIL data_ptr: got x=%0d y=%0d, want 35 2", x_addr, y_addr);
    end
    checks++;
    if (byte_data !== 8'h81 || byte_dc !== 1'b1) begin
      failures++; $display("FAIL data_last_byte: got %h dc=%b, want 81 1", byte_data, byte_dc);
    end
    read_ram(9'd201, d);
    checks++;
    if (d !== 8'hFE) begin
      failures++; $display("FAIL ram_201: got %h, want fe", d);
    end
    read_ram(9'd202, d);
    checks++;
    if (d !== 8'h81) begin
      failures++; $display("FAIL ram_202: got %h, want 81", d);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    send_cmd(8'hD3);
    send_cmd(8'h45);
    send_data(8'h3C);
    read_ram(9'd503, d);
    checks++;
    if (d !== 8'h3C) begin
      failures++; $display("FAIL wrap_h_ram503: got %h, want 3c", d);
    end
    checks++;
    if (x_addr !== 7'd0 || y_addr !== 3'd0) begin
      failures++; $display("FAIL wrap_h_ptr: got x=%0d y=%0d, want 0 0", x_addr, y_addr);
    end
    send_cmd(8'h22);
    send_cmd(8'h8A);
    send_cmd(8'h45);
    send_data(8'h5A);
    checks++;
    if (x_addr !== 7'd11 || y_addr !== 3'd0) begin
      failures++; $display("FAIL wrap_v_ptr: got x=%0d y=%0d, want 11 0", x_addr, y_addr);
    end
    read_ram(9'd430, d);
    checks++;
    if (d !== 8'h5A) begin
      failures++; $display("FAIL wrap_v_ram430: got %h, want 5a", d);
    end
    send_cmd(8'h20);
  endtask

  task automatic test_frame_err;
    logic [7:0] d;
    int bv0, fe0, ce0;
    send_cmd(8'h85);
    send_cmd(8'h41);
    send_data(8'h11);
    send_cmd(8'h85);
    bv0 = bv_cnt; fe0 = fe_cnt;
    spi_send(8'hFF, 1'b1, 5, 1'b1);
    checks++;
    if (fe_cnt - fe0 != 1 || bv_cnt - bv0 != 0) begin
      failures++; $display("FAIL frame_pulses: got frame_err=%0d byte_valid=%0d, want 1 0",
                           fe_cnt - fe0, bv_cnt - bv0);
    end
    checks++;
    if (x_addr !== 7'd5 || y_addr !== 3'd1) begin
      failures++; $display("FAIL frame_ptr: got x=%0d y=%0d, want 5 1", x_addr, y_addr);
    end
    read_ram(9'd89, d);
    checks++;
    if (d !== 8'h11) begin
      failures++; $display("FAIL frame_ram89: got %h, want 11", d);
    end
    bv0 = bv_cnt; ce0 = ce_cnt;
    send_cmd(8'h83);
    checks++;
    if (x_addr !== 7'd3 || bv_cnt - bv0 != 1 || ce_cnt - ce0 != 0) begin
      failures++; $display("FAIL frame_recover: got x=%0d bv=%0d ce=%0d, want 3 1 0",
                           x_addr, bv_cnt - bv0, ce_cnt - ce0);
    end
  endtask

  task automatic test_cmd_err;
    int ce0;
    ce0 = ce_cnt;
    send_cmd(8'hD5);
    checks++;
    if (ce_cnt - ce0 != 1 || x_addr !== 7'd3) begin
      failures++; $display("FAIL cmd_err_x85: got ce=%0d x=%0d, want 1 3", ce_cnt - ce0, x_addr);
    end
    send_cmd(8'h47);
    checks++;
    if (ce_cnt - ce0 != 2 || y_addr !== 3'd1) begin
      failures++; $display("FAIL cmd_err_y7: got ce=%0d y=%0d, want 2 1", ce_cnt - ce0, y_addr);
    end
    send_cmd(8'h0E);
    checks++;
    if (ce_cnt - ce0 != 3 || disp_mode !== 2'b10) begin
      failures++; $display("FAIL cmd_err_undef: got ce=%0d D=%b, want 3 10", ce_cnt - ce0, disp_mode);
    end
  endtask

  task automatic test_lcd_reset;
    logic [7:0] d;
    int bv0, ce0, fe0;
    spi_send(8'hFF, 1'b0, 3, 1'b0);
    lcd_rst_n = 1'b0;
    repeat (6) @(negedge clock);
    checks++;
    if ({x_addr, y_addr, h_ext, v_mode, power_down, disp_mode} !== 15'b0000000_000_00100) begin
      failures++; $display("FAIL lcdrst_regs: got x=%0d y=%0d H=%b V=%b PD=%b D=%b, want 0 0 0 0 1 00",
                           x_addr, y_addr, h_ext, v_mode, power_down, disp_mode);
    end
    checks++;
    if ({vop, bias, tc, byte_data, byte_dc} !== 21'd0) begin
      failures++; $display("FAIL lcdrst_vals: got vop=%h bias=%h tc=%h bd=%h dc=%b, want 0",
                           vop, bias, tc, byte_data, byte_dc);
    end
    lcd_rst_n = 1'b1;
    repeat (4) @(negedge clock);
    fe0 = fe_cnt;
    sce = 1'b1;
    repeat (6) @(negedge clock);
    bv0 = bv_cnt; ce0 = ce_cnt;
    send_cmd(8'hC5);
    checks++;
    if (x_addr !== 7'd69 || byte_data !== 8'hC5 || bv_cnt - bv0 != 1 || ce_cnt - ce0 != 0) begin
      failures++; $display("FAIL lcdrst_next_byte: got x=%0d bd=%h bv=%0d ce=%0d, want 69 c5 1 0",
                           x_addr, byte_data, bv_cnt - bv0, ce_cnt - ce0);
    end
    checks++;
    if (fe_cnt - fe0 != 0) begin
      failures++; $display("FAIL lcdrst_no_frame_err: got %0d, want 0", fe_cnt - fe0);
    end
    read_ram(9'd89, d);
    checks++;
    if (d !== 8'h11) begin
      failures++; $display("FAIL lcdrst_ram89: got %h, want 11", d);
    end
    read_ram(9'd503, d);
    checks++;
    if (d !== 8'h3C) begin
      failures++; $display("FAIL lcdrst_ram503: got %h, want 3c", d);
    end
  endtask

  task automatic test_read_range;
    logic [7:0] d;
    read_ram(9'd504, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL rd_504: got %h, want 00", d);
    end
    read_ram(9'd511, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL rd_511: got %h, want 00", d);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_data();
    test_wrap();
    test_frame_err();
    test_cmd_err();
    test_lcd_reset();
    test_read_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
